// File: rtl/lsu_pkg.sv
// lsu_pkg: shared width codes, fault causes and FSM states for the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE    = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: pick the addressed byte/half out of a read word and extend it
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [31:0] sh;

    // word loads are always aligned, so the shifted word doubles as the W result
    assign sh = word_i >> {offset_i, 3'b000};

    // extend the selected lane according to the load width
    always_comb
        data_o = funct3_i == F3_B  ? {{24{sh[7]}}, sh[7:0]}   :
                 funct3_i == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                 funct3_i == F3_BU ? {24'd0, sh[7:0]}         :
                 funct3_i == F3_HU ? {16'd0, sh[15:0]}        : sh;
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the core MEM stage and a byte-enabled data memory
module lsu
    import lsu_pkg::*;
#(
    parameter int MEMORY_SIZE  = 12288,
    parameter int ADDR_WIDTH   = $clog2(MEMORY_SIZE),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic [1:0]            rsp_cause,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [3:0]            mem_byteena,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    localparam int CW = $clog2(READ_LATENCY + 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic            accept, illegal, misalign, range, good;
    logic [1:0]      cause;
    logic [3:0]      mask;
    logic [31:0]     load_data;

    assign req_ready = rst_n && state_q == IDLE;
    assign accept    = req_valid && req_ready;

    // classify the request; illegal width wins over misalignment, which wins over range
    always_comb begin
        illegal  = req_we ? req_funct3 > F3_W : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        range    = req_addr >= 32'(MEMORY_SIZE);
        cause    = illegal ? CAUSE_ILLEGAL : misalign ? CAUSE_MISALIGN : range ? CAUSE_RANGE : CAUSE_NONE;
        good     = accept && cause == CAUSE_NONE;
    end

    // drive the memory port straight from the request; strobes only for good accepts
    always_comb begin
        mask        = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                      req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
        mem_addr    = req_addr[ADDR_WIDTH-1:0];
        mem_we      = good && req_we;
        mem_re      = good && !req_we;
        mem_byteena = good ? mask : 4'b0000;
        mem_wdata   = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}}  :
                      req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    end

    lsu_load_align u_align (
        .word_i   (mem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    // sequence each access: wait out the read latency for loads, then pulse one response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_fault <= 1'b0;
            rsp_cause <= CAUSE_NONE;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    off_q <= req_addr[1:0];
                    f3_q  <= req_funct3;
                    if (good && !req_we) begin
                        state_q <= WAIT;
                        cnt_q   <= CW'(READ_LATENCY - 1);
                    end else begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'd0;
                        rsp_fault <= cause != CAUSE_NONE;
                        rsp_cause <= cause;
                    end
                end
                WAIT: if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    state_q   <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                    rsp_fault <= 1'b0;
                    rsp_cause <= CAUSE_NONE;
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu against a byte-array reference model
module tb_lsu;
    localparam int MS = 12288;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  cause;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_fault, mem_we, mem_re;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [1:0]  rsp_cause;
    logic [13:0] mem_addr, raddr_q;
    logic [3:0]  mem_byteena;

    logic [7:0]  mem [MS];
    logic [7:0]  ref_mem [MS];
    exp_t        exp_q [$];
    exp_t        me;
    int          checks = 0, failures = 0, cyc = 0, acc_cyc = 0;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_byteena(mem_byteena),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // data memory with an address register and an output register
    always @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_byteena[i]) mem[{mem_addr[13:2], 2'(i)}] <= mem_wdata[8*i +: 8];
        if (mem_re) raddr_q <= mem_addr;
        mem_rdata <= {mem[{raddr_q[13:2], 2'd3}], mem[{raddr_q[13:2], 2'd2}],
                      mem[{raddr_q[13:2], 2'd1}], mem[{raddr_q[13:2], 2'd0}]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f);
        return f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [1:0] ref_cause(input logic we, input logic [2:0] f, input logic [31:0] a);
        bit ill;
        ill = we ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
        if (ill) return 2'd3;
        if (a % sz(f) != 0) return 2'd1;
        if (a >= MS) return 2'd2;
        return 2'd0;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        int n = 0;
        int s;
        logic [1:0] c;
        logic [3:0] be;
        logic [31:0] v, wd;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_we = we; req_funct3 = f; req_addr = a; req_wdata = d; req_valid = 1'b1;
        #1;
        c  = ref_cause(we, f, a);
        s  = sz(f);
        be = c == 2'd0 ? 4'(((1 << s) - 1) << (a % 4)) : 4'd0;
        chk("mem_re", 32'(mem_re), 32'(c == 2'd0 && !we));
        chk("mem_we", 32'(mem_we), 32'(c == 2'd0 && we));
        chk("mem_byteena", 32'(mem_byteena), 32'(be));
        chk("mem_addr", 32'(mem_addr), 32'(a[13:0]));
        v = 32'd0;
        if (c == 2'd0 && we) begin
            wd = s == 1 ? {4{d[7:0]}} : s == 2 ? {2{d[15:0]}} : d;
            chk("mem_wdata", mem_wdata, wd);
            for (int i = 0; i < s; i++) ref_mem[a + i] = d[8*i +: 8];
        end
        if (c == 2'd0 && !we) begin
            for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[a + i];
            if (!f[2] && s == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f[2] && s == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        e.rdata = v;
        e.fault = c != 2'd0;
        e.cause = c;
        e.cyc   = cyc + ((c == 2'd0 && !we) ? 3 : 1);
        exp_q.push_back(e);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // scoreboard monitor: every response pulse must match the oldest outstanding access
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                me = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, me.rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(me.fault));
                chk("rsp_cause", 32'(rsp_cause), 32'(me.cause));
                chk("rsp_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
    end

    initial begin
        int prev;
        logic [2:0] lf [5];
        logic [2:0] f;
        logic [31:0] a;
        int r;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < MS; i++) begin
            mem[i] <= 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end

        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd0; req_funct3 = 3'd2;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset_rsp_cause", 32'(rsp_cause), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_mem_re", 32'(mem_re), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0);
        issue(1, 3'd0, 32'h103, 32'h0000_00A5, 0);
        issue(0, 3'd0, 32'h103, 32'd0, 0);
        issue(0, 3'd4, 32'h103, 32'd0, 0);
        issue(1, 3'd2, 32'h100, 32'h8001_7FFF, 0);
        issue(0, 3'd1, 32'h102, 32'd0, 0);
        issue(0, 3'd5, 32'h102, 32'd0, 0);
        issue(0, 3'd1, 32'h100, 32'd0, 0);
        issue(0, 3'd2, 32'h100, 32'd0, 0);
        issue(0, 3'd2, 32'h101, 32'd0, 0);
        issue(1, 3'd2, 32'h3000, 32'h1234_5678, 0);
        issue(1, 3'd5, 32'h101, 32'h1234_5678, 0);
        issue(0, 3'd3, 32'h0, 32'd0, 0);
        issue(0, 3'd2, 32'h2FFC, 32'd0, 0);

        issue(0, 3'd2, 32'h0, 32'd0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_after", 32'(req_ready), 32'd1);
        chk("midrst_no_rsp_n2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_no_rsp_n3", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_no_rsp_n4", 32'(rsp_valid), 32'd0);

        for (int k = 0; k < 6; k++) begin
            f = lf[$urandom_range(0, 4)];
            a = $urandom_range(0, MS - 1) & ~(sz(f) - 1);
            prev = acc_cyc;
            issue(0, f, a, 32'd0, 1);
            if (k > 0) chk("b2b_spacing", 32'(acc_cyc - prev), 32'd4);
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                #1;
                chk("b2b_ready_low", 32'(req_ready), 32'd0);
                chk("b2b_no_strobe", 32'({mem_re, mem_we}), 32'd0);
            end
        end
        req_valid = 1'b0;

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            f = 3'($urandom_range(0, 7));
            a = r == 0 ? $urandom : r == 1 ? 32'(MS - 8 + $urandom_range(0, 15)) : 32'($urandom_range(0, MS - 1));
            if (r > 5) a = a & ~32'(sz(f) - 1);
            issue(1'($urandom_range(0, 1)), f, a, $urandom, 0);
        end

        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
